// File: rtl/alu_bist_driver.sv
// Self-test initiator for the 32-bit ALU: LFSR operands, opcode sweep, golden compare.
// Define ALU_BIST_SLT_EN to add SLT (4'b0111) to the opcode sweep.
module alu_bist_driver #(
  parameter int          NUM_VECTORS   = 16,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED          = 32'h00000001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] error_count,
  output logic [31:0] fail_a,
  output logic [31:0] fail_b,
  output logic [3:0]  fail_op,
  output logic [31:0] fail_result
);

  localparam logic [31:0] SEED_V = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY   = 32'h80200003;
`ifdef ALU_BIST_SLT_EN
  localparam logic [2:0]  NOPS   = 3'd5;
`else
  localparam logic [2:0]  NOPS   = 3'd4;
`endif

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, SETTLE, CHECK, FINISH
  } state_t;

  state_t      state, state_n;
  logic [31:0] lfsr, lfsr_nx;
  logic [15:0] idx;
  logic [2:0]  sel;
  logic [15:0] cnt;
  logic [31:0] exp_res;
  logic        mismatch;
  logic        last;

  assign lfsr_nx = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
  assign last    = (idx == 16'(NUM_VECTORS - 1));
  assign busy    = (state != IDLE);

  function automatic logic [3:0] op_of(input logic [2:0] s);
    case (s)
      3'd0:    op_of = 4'b0000;
      3'd1:    op_of = 4'b0001;
      3'd2:    op_of = 4'b0010;
      3'd3:    op_of = 4'b0110;
      default: op_of = 4'b0111;
    endcase
  endfunction

  always_comb begin
    exp_res = 32'h0;
    case (alu_op)
      4'b0000: exp_res = alu_a & alu_b;
      4'b0001: exp_res = alu_a | alu_b;
      4'b0010: exp_res = alu_a + alu_b;
      4'b0110: exp_res = alu_a - alu_b;
`ifdef ALU_BIST_SLT_EN
      4'b0111: exp_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
`endif
      default: exp_res = 32'h0;
    endcase
  end

  assign mismatch = (alu_result != exp_res) ||
                    (alu_zero != (exp_res == 32'h0));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = LOAD_A;
      LOAD_A:  state_n = LOAD_B;
      LOAD_B:  state_n = SETTLE;
      SETTLE:  if (cnt == 16'd1) state_n = CHECK;
      CHECK:   state_n = last ? FINISH : LOAD_A;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lfsr        <= SEED_V;
      idx         <= 16'd0;
      sel         <= 3'd0;
      cnt         <= 16'd0;
      alu_a       <= 32'h0;
      alu_b       <= 32'h0;
      alu_op      <= 4'h0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_count <= 16'h0;
      fail_a      <= 32'h0;
      fail_b      <= 32'h0;
      fail_op     <= 4'h0;
      fail_result <= 32'h0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (start) begin
          done        <= 1'b0;
          pass        <= 1'b0;
          error_count <= 16'h0;
          fail_a      <= 32'h0;
          fail_b      <= 32'h0;
          fail_op     <= 4'h0;
          fail_result <= 32'h0;
          lfsr        <= SEED_V;
          idx         <= 16'd0;
          sel         <= 3'd0;
        end
        LOAD_A: begin
          alu_a <= lfsr;
          lfsr  <= lfsr_nx;
        end
        LOAD_B: begin
          alu_b  <= lfsr;
          lfsr   <= lfsr_nx;
          alu_op <= op_of(sel);
          cnt    <= 16'(SETTLE_CYCLES);
        end
        SETTLE: cnt <= cnt - 16'd1;
        CHECK: begin
          if (mismatch) begin
            if (error_count != 16'hFFFF)
              error_count <= error_count + 16'd1;
            // Only the first failing vector of a run is recorded
            if (error_count == 16'h0) begin
              fail_a      <= alu_a;
              fail_b      <= alu_b;
              fail_op     <= alu_op;
              fail_result <= alu_result;
            end
          end
          if (!last) begin
            idx <= idx + 16'd1;
            sel <= (sel == NOPS - 3'd1) ? 3'd0 : sel + 3'd1;
          end
        end
        FINISH: begin
          done <= 1'b1;
          pass <= (error_count == 16'h0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: faultable ALU model, per-cycle reference compare.
module tb_alu_bist_driver;

  localparam int NV     = 8;
  localparam int SETTLE = 1;
  localparam int PER    = 3 + SETTLE;
`ifdef ALU_BIST_SLT_EN
  localparam int NOPS = 5;
`else
  localparam int NOPS = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        busy, done, pass;
  logic [15:0] error_count;
  logic [31:0] fail_a, fail_b, fail_result;
  logic [3:0]  fail_op;

  int mode = 0;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_bist_driver #(
    .NUM_VECTORS(NV), .SETTLE_CYCLES(SETTLE), .SEED(32'h1)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .done(done), .pass(pass),
    .error_count(error_count),
    .fail_a(fail_a), .fail_b(fail_b),
    .fail_op(fail_op), .fail_result(fail_result)
  );

  function automatic logic [31:0] gold(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  // ALU under test; mode 1: ADD gives 0, 2: zero stuck at 1, 3: bit0 flipped when a[3]
  function automatic logic [32:0] dev(logic [31:0] a, logic [31:0] b, logic [3:0] op, int m);
    logic [31:0] r;
    logic z;
    r = gold(a, b, op);
    if (m == 1 && op == 4'b0010) r = 32'h0;
    if (m == 3 && a[3]) r = r ^ 32'h1;
    z = (m == 2) ? 1'b1 : (r == 32'h0);
    return {z, r};
  endfunction

  assign {alu_zero, alu_result} = dev(alu_a, alu_b, alu_op, mode);

  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [3:0]  vop[NV];

  function automatic logic [3:0] opc(int i);
    case (i % NOPS)
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [31:0] nx(logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic bit mism(int j, int m);
    logic [31:0] g;
    g = gold(va[j], vb[j], vop[j]);
    return dev(va[j], vb[j], vop[j], m) != {g == 32'h0, g};
  endfunction

  function automatic int cnt_upto(int n, int m);
    int c = 0;
    for (int j = 0; j < n; j++) if (mism(j, m)) c++;
    return c;
  endfunction

  function automatic int first_fail(int m);
    for (int j = 0; j < NV; j++) if (mism(j, m)) return j;
    return 0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
  endtask

  // Reference timeline: k = edges since the accepting start edge, -1 when idle
  int k = -1;
  bit mdone = 0;
  bit clean = 1;
  int run_mode = 0;
  bit armed = 0;

  always @(posedge clk) begin
    if (reset) begin
      k <= -1; mdone <= 0; clean <= 1;
    end else if (k < 0) begin
      if (start) begin
        k <= 0; mdone <= 0; clean <= 0; run_mode <= mode;
      end
    end else if (k == PER * NV) begin
      k <= -1; mdone <= 1;
    end else begin
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    int c, f, v;
    if (armed) begin
      chk("busy", 32'(busy), 32'(k >= 0));
      chk("done", 32'(done), 32'(mdone));
      if (k < 0 && clean) begin
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_op", 32'(alu_op), 0);
        chk("rst_ec", 32'(error_count), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_fa", fail_a, 0);
        chk("rst_fr", fail_result, 0);
      end else begin
        c = (k >= 0) ? cnt_upto(k / PER, run_mode) : cnt_upto(NV, run_mode);
        chk("ec", 32'(error_count), 32'(c));
        chk("pass", 32'(pass), 32'(mdone && c == 0));
        f = first_fail(run_mode);
        chk("fail_a", fail_a, (c > 0) ? va[f] : 32'h0);
        chk("fail_b", fail_b, (c > 0) ? vb[f] : 32'h0);
        chk("fail_op", 32'(fail_op), (c > 0) ? 32'(vop[f]) : 32'h0);
        chk("fail_res", fail_result,
            (c > 0) ? dev(va[f], vb[f], vop[f], run_mode) & 33'hFFFFFFFF : 32'h0);
        if (k >= 0 && k < PER * NV && (k % PER) >= 2) begin
          v = k / PER;
          chk("alu_a", alu_a, va[v]);
          chk("alu_b", alu_b, vb[v]);
          chk("alu_op", 32'(alu_op), 32'(vop[v]));
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  initial begin
    logic [31:0] l;
    int n;
    l = 32'h1;
    for (int i = 0; i < NV; i++) begin
      va[i] = l; l = nx(l);
      vb[i] = l; l = nx(l);
      vop[i] = opc(i);
    end

    repeat (3) @(posedge clk);
    #1 armed = 1;
    reset = 1'b0;

    // Correct ALU, literal vectors and latency
    mode = 0;
    pulse_start();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) begin
        chk("v0_a", alu_a, 32'h00000001);
        chk("v0_b", alu_b, 32'h80200003);
        chk("v0_op", 32'(alu_op), 32'h0);
      end
      if (n == 6) begin
        chk("v1_a", alu_a, 32'hC0300002);
        chk("v1_b", alu_b, 32'h60180001);
        chk("v1_op", 32'(alu_op), 32'h1);
        chk("v1_res", alu_result, 32'hE0380003);
      end
      if (done) break;
    end
    chk("done_latency", 32'(n), 32'(PER * NV + 1));
    chk("run0_pass", 32'(pass), 1);
    chk("run0_ec", 32'(error_count), 0);

    // ADD forced to zero
    mode = 1;
    pulse_start();
    wait_done(n);
    chk("add0_ec", 32'(error_count), 2);
    chk("add0_pass", 32'(pass), 0);
    chk("add0_op", 32'(fail_op), 32'h2);
    chk("add0_a", fail_a, 32'hB02C0003);
    chk("add0_b", fail_b, 32'hD8360002);
    chk("add0_res", fail_result, 32'h0);

    // Zero flag stuck at 1
    mode = 2;
    pulse_start();
    wait_done(n);
`ifndef ALU_BIST_SLT_EN
    chk("zst_ec", 32'(error_count), 32'(NV));
`endif
    chk("zst_model_ec", 32'(error_count), 32'(cnt_upto(NV, 2)));

    // Reset in SETTLE, then rerun from seed
    mode = 0;
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_a", alu_a, 32'h0);
    chk("mid_rst_op", 32'(alu_op), 32'h0);
    pulse_start();
    wait_done(n);
    chk("rerun_pass", 32'(pass), 1);

    // Start coincident with reset is ignored
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("rst_start_busy", 32'(busy), 0);

    // Random fault modes with stray start pulses mid-run
    for (int r = 0; r < 6; r++) begin
      mode = $urandom_range(0, 3);
      pulse_start();
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        if (done) break;
        start = ($urandom_range(0, 5) == 0);
      end
      start = 1'b0;
      chk("rand_done", 32'(done), 1);
      chk("rand_ec", 32'(error_count), 32'(cnt_upto(NV, mode)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1 armed = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
